lifo_stack: RTL and testbench

- Parametrised successor to the fixed 12-deep stack: a last-in/first-out stack of DEPTH elements of WIDTH bits, with s0 and s1 exposed as registered outputs.
- Adds an occupancy count, full/empty flags, sticky overflow/underflow error flags, a DUP operation and a synchronous clear.
- Sits beside the CPU datapath as an operand or return stack.
- Every stack operation completes in a single cycle.

---
 rtl/lifo_stack.sv | 109 ++++++++++
 tb/tb_lifo_stack.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/lifo_stack.sv
// Parametrised LIFO stack (DEPTH x WIDTH), s0/s1 registered, count and sticky error flags.
// Every operation completes in one cycle; no backpressure: overflow drops the bottom element, errors set sticky flags.
module lifo_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 12,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_swap,
    input  logic             i_dup,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_s0,
    output logic [WIDTH-1:0] o_s1,
    output logic [CNT_W-1:0] o_count,
    output logic             o_empty,
    output logic             o_full,
    output logic             o_ovf,
    output logic             o_unf
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    logic [WIDTH-1:0] stk [DEPTH];
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic             unf;
    logic [WIDTH-1:0] push_dat;
    logic             is_empty;
    logic             is_full;

    assign is_empty = (cnt == '0);
    assign is_full  = (cnt == DEPTH_C);

    // dup is tested ahead of push, so i_dup alone selects the data source
    always_comb begin
        push_dat = i_data;
        if (i_dup) begin
            push_dat = stk[0];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                stk[k] <= '0;
            end
            cnt <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else if (i_clr) begin
            for (int k = 0; k < DEPTH; k++) begin
                stk[k] <= '0;
            end
            cnt <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else if (i_swap) begin
            if (cnt > ONE_C) begin
                stk[0] <= stk[1];
                stk[1] <= stk[0];
            end else begin
                unf <= 1'b1;
            end
        end else if (i_push && i_pop) begin
            if (is_empty) begin
                unf <= 1'b1;
            end else begin
                stk[0] <= i_data;
            end
        end else if (i_dup && is_empty) begin
            unf <= 1'b1;
        end else if (i_dup || i_push) begin
            // a full stack loses its bottom element off the end of the shift
            for (int k = DEPTH - 1; k > 0; k--) begin
                stk[k] <= stk[k-1];
            end
            stk[0] <= push_dat;
            if (is_full) begin
                ovf <= 1'b1;
            end else begin
                cnt <= cnt + ONE_C;
            end
        end else if (i_pop) begin
            if (is_empty) begin
                unf <= 1'b1;
            end else begin
                for (int k = 0; k < DEPTH - 1; k++) begin
                    stk[k] <= stk[k+1];
                end
                stk[DEPTH-1] <= '0;
                cnt <= cnt - ONE_C;
            end
        end
    end

    assign o_s0    = stk[0];
    assign o_s1    = stk[1];
    assign o_count = cnt;
    assign o_empty = is_empty;
    assign o_full  = is_full;
    assign o_ovf   = ovf;
    assign o_unf   = unf;

endmodule

// File: tb/tb_lifo_stack.sv
// Bench for lifo_stack: queue-based reference model checked every cycle, plus directed literal checks.
module tb_lifo_stack;

    localparam int WIDTH = 8;
    localparam int DEPTH = 12;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             i_clk = 1'b0;
    logic             i_rst_n = 1'b1;
    logic [WIDTH-1:0] i_data = '0;
    logic             i_push = 1'b0;
    logic             i_pop = 1'b0;
    logic             i_swap = 1'b0;
    logic             i_dup = 1'b0;
    logic             i_clr = 1'b0;
    logic [WIDTH-1:0] o_s0;
    logic [WIDTH-1:0] o_s1;
    logic [CNT_W-1:0] o_count;
    logic             o_empty;
    logic             o_full;
    logic             o_ovf;
    logic             o_unf;

    int vectors = 0;
    int miscompares = 0;

    lifo_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_data(i_data),
        .i_push(i_push), .i_pop(i_pop), .i_swap(i_swap), .i_dup(i_dup), .i_clr(i_clr),
        .o_s0(o_s0), .o_s1(o_s1), .o_count(o_count), .o_empty(o_empty),
        .o_full(o_full), .o_ovf(o_ovf), .o_unf(o_unf)
    );

    always #5 i_clk = ~i_clk;

    // Reference model: queue always holds DEPTH entries, index 0 is top of stack.
    logic [WIDTH-1:0] mq[$];
    int mcnt;
    bit movf, munf;

    function automatic void m_reset();
        mq.delete();
        for (int k = 0; k < DEPTH; k++) mq.push_back('0);
        mcnt = 0;
        movf = 1'b0;
        munf = 1'b0;
    endfunction

    function automatic void m_push(logic [WIDTH-1:0] v);
        mq.push_front(v);
        void'(mq.pop_back());
        if (mcnt == DEPTH) movf = 1'b1;
        else mcnt++;
    endfunction

    function automatic void m_step();
        logic [WIDTH-1:0] t;
        if (i_clr) m_reset();
        else if (i_swap) begin
            if (mcnt < 2) munf = 1'b1;
            else begin
                t = mq[0]; mq[0] = mq[1]; mq[1] = t;
            end
        end else if (i_push && i_pop) begin
            if (mcnt == 0) munf = 1'b1;
            else mq[0] = i_data;
        end else if (i_dup) begin
            if (mcnt == 0) munf = 1'b1;
            else m_push(mq[0]);
        end else if (i_push) m_push(i_data);
        else if (i_pop) begin
            if (mcnt == 0) munf = 1'b1;
            else begin
                void'(mq.pop_front());
                mq.push_back('0);
                mcnt--;
            end
        end
    endfunction

    initial m_reset();

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) m_reset();
        else m_step();
    end

    task automatic chk(string nm, int act, int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge i_clk) begin
        chk("m_s0", int'(o_s0), int'(mq[0]));
        chk("m_s1", int'(o_s1), int'(mq[1]));
        chk("m_count", int'(o_count), mcnt);
        chk("m_empty", int'(o_empty), int'(mcnt == 0));
        chk("m_full", int'(o_full), int'(mcnt == DEPTH));
        chk("m_ovf", int'(o_ovf), int'(movf));
        chk("m_unf", int'(o_unf), int'(munf));
    end

    // Apply one request for exactly one rising edge, then return to idle.
    task automatic op(bit pu, bit po, bit sw, bit du, bit cl, logic [WIDTH-1:0] d);
        @(negedge i_clk);
        i_push = pu; i_pop = po; i_swap = sw; i_dup = du; i_clr = cl; i_data = d;
        @(posedge i_clk);
        #1;
        i_push = 0; i_pop = 0; i_swap = 0; i_dup = 0; i_clr = 0;
    endtask

    task automatic push(logic [WIDTH-1:0] d); op(1, 0, 0, 0, 0, d); endtask
    task automatic pop();                     op(0, 1, 0, 0, 0, '0); endtask
    task automatic clr();                     op(0, 0, 0, 0, 1, '0); endtask

    initial begin
        #1 i_rst_n = 1'b0;
        #1;
        chk("rst_s0", int'(o_s0), 0);
        chk("rst_count", int'(o_count), 0);
        chk("rst_empty", int'(o_empty), 1);
        chk("rst_flags", int'({o_ovf, o_unf}), 0);
        #21 i_rst_n = 1'b1;

        // basic pushes
        push(8'h11); push(8'h22); push(8'h33);
        chk("p3_s0", int'(o_s0), 'h33);
        chk("p3_s1", int'(o_s1), 'h22);
        chk("p3_count", int'(o_count), 3);
        chk("p3_empty", int'(o_empty), 0);
        chk("p3_flags", int'({o_ovf, o_unf}), 0);

        // replace, swap, pop
        op(1, 1, 0, 0, 0, 8'h44);
        chk("rep_s0", int'(o_s0), 'h44);
        chk("rep_s1", int'(o_s1), 'h22);
        op(0, 0, 1, 0, 0, '0);
        chk("swp_s0", int'(o_s0), 'h22);
        chk("swp_s1", int'(o_s1), 'h44);
        pop();
        chk("pop_s0", int'(o_s0), 'h44);
        chk("pop_s1", int'(o_s1), 'h11);
        chk("pop_count", int'(o_count), 2);

        // fill, overflow, drain
        clr();
        for (int v = 1; v <= DEPTH; v++) push(WIDTH'(v));
        chk("fill_full", int'(o_full), 1);
        push(8'd13);
        chk("ovf_count", int'(o_count), DEPTH);
        chk("ovf_s0", int'(o_s0), 13);
        chk("ovf_s1", int'(o_s1), 12);
        chk("ovf_flag", int'(o_ovf), 1);
        for (int n = 0; n < DEPTH - 1; n++) pop();
        chk("last_pop_val", int'(o_s0), 2);
        pop();
        chk("drain_empty", int'(o_empty), 1);

        // underflow on empty stack
        clr();
        pop();
        op(0, 0, 1, 0, 0, '0);
        op(0, 0, 0, 1, 0, '0);
        chk("unf_count", int'(o_count), 0);
        chk("unf_s0s1", int'({o_s0, o_s1}), 0);
        chk("unf_flag", int'(o_unf), 1);
        push(8'h5A);
        op(0, 0, 0, 1, 0, '0);
        chk("dup_s0", int'(o_s0), 'h5A);
        chk("dup_s1", int'(o_s1), 'h5A);
        chk("dup_count", int'(o_count), 2);
        chk("dup_unf", int'(o_unf), 1);
        clr();
        chk("clr_count", int'(o_count), 0);
        chk("clr_unf", int'(o_unf), 0);

        // priority: swap beats replace/push/pop
        push(8'h0B); push(8'h0A);
        op(1, 1, 1, 0, 0, 8'hEE);
        chk("prio_s0", int'(o_s0), 'h0B);
        chk("prio_s1", int'(o_s1), 'h0A);
        chk("prio_count", int'(o_count), 2);

        // asynchronous reset mid-cycle
        clr();
        for (int v = 0; v < 5; v++) push(WIDTH'(8'h70 + v));
        chk("pre_arst_count", int'(o_count), 5);
        #2 i_rst_n = 1'b0;
        #1;
        chk("arst_count", int'(o_count), 0);
        chk("arst_s0s1", int'({o_s0, o_s1}), 0);
        @(negedge i_clk);
        #1 i_rst_n = 1'b1;
        push(8'h99);
        chk("post_arst_count", int'(o_count), 1);

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            @(negedge i_clk);
            i_push = ($urandom_range(0, 99) < 50);
            i_pop  = ($urandom_range(0, 99) < 40);
            i_swap = ($urandom_range(0, 99) < 12);
            i_dup  = ($urandom_range(0, 99) < 12);
            i_clr  = ($urandom_range(0, 99) < 2);
            i_data = WIDTH'($urandom);
        end
        @(negedge i_clk);
        i_push = 0; i_pop = 0; i_swap = 0; i_dup = 0; i_clr = 0;
        repeat (3) @(negedge i_clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
